// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

  // Slot counter width; at least one bit so small frames still have a counter.
  function automatic int unsigned slot_w(input int unsigned n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter with clear, load-to-1 and increment, plus terminal-count flag.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned N_CH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_load1,
  input  logic                      i_en,
  output logic [slot_w(N_CH)-1:0]   o_slot,
  output logic                      o_tc
);

  localparam int unsigned SW = slot_w(N_CH);

  logic [SW-1:0] r_slot;
  logic          w_tc;

  assign w_tc = (r_slot == SW'(N_CH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
    end else if (i_clr) begin
      r_slot <= '0;
    end else if (i_load1) begin
      r_slot <= SW'(1);
    end else if (i_en) begin
      r_slot <= w_tc ? '0 : r_slot + 1'b1;
    end
  end

  assign o_slot = r_slot;
  assign o_tc   = w_tc;

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: routes each beat to its channel register and tracks frame lock.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned N_CH = 8,
  parameter int unsigned W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  input  logic              in_sof,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  localparam int unsigned SW = slot_w(N_CH);

  state_t                    r_state;
  logic [N_CH-1:0][W-1:0]    r_ch;
  logic [N_CH-1:0]           r_ch_valid;
  logic                      r_frame_done;
  logic                      r_sync_err;

  state_t                    w_state_d;
  logic [SW-1:0]             w_slot;
  logic                      w_tc;
  logic                      w_wr;
  logic [SW-1:0]             w_idx;
  logic                      w_clr;
  logic                      w_load1;
  logic                      w_en;
  logic                      w_fd;
  logic                      w_err;

  tdm_slot_counter #(
    .N_CH (N_CH)
  ) u_slot_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_load1 (w_load1),
    .i_en    (w_en),
    .o_slot  (w_slot),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_state_d = r_state;
    w_wr      = 1'b0;
    w_idx     = '0;
    w_clr     = 1'b0;
    w_load1   = 1'b0;
    w_en      = 1'b0;
    w_fd      = 1'b0;
    w_err     = 1'b0;
    if (in_valid) begin
      unique case (r_state)
        HUNT: begin
          if (in_sof) begin
            w_wr      = 1'b1;
            w_load1   = 1'b1;
            w_state_d = SYNC;
          end
        end
        SYNC: begin
          if (in_sof) begin
            // Early marker realigns onto slot 0 without leaving SYNC.
            w_wr    = 1'b1;
            w_load1 = 1'b1;
            w_err   = (w_slot != '0);
          end else if (w_slot == '0) begin
            w_err     = 1'b1;
            w_clr     = 1'b1;
            w_state_d = HUNT;
          end else begin
            w_wr  = 1'b1;
            w_idx = w_slot;
            w_en  = 1'b1;
            w_fd  = w_tc;
          end
        end
        default: w_state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_ch         <= '0;
      r_ch_valid   <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_ch_valid   <= '0;
      r_frame_done <= w_fd;
      r_sync_err   <= w_err;
      if (w_wr) begin
        r_ch[w_idx]       <= in_data;
        r_ch_valid[w_idx] <= 1'b1;
      end
    end
  end

  assign ch_data    = r_ch;
  assign ch_valid   = r_ch_valid;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign locked     = (r_state == SYNC);

endmodule
